// File: rtl/vmem_fill_ctrl_pkg.sv
// vmem_fill_ctrl_pkg
// Shared definitions for the rectangle-fill engine and its write-port arbiter:
// register byte offsets, CTRL/status bit positions, FSM state encoding and a
// clipping helper that computes the exclusive end coordinate of a span.
package vmem_fill_ctrl_pkg;

    localparam int SCREEN_W_DEF = 240;
    localparam int SCREEN_H_DEF = 240;

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_ORIGIN = 4'h4;
    localparam logic [3:0] REG_SIZE   = 4'h8;
    localparam logic [3:0] REG_COLOR  = 4'hC;

    // CTRL write bits
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_ABORT_BIT = 1;

    // CTRL read bits
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_ERR_BIT  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fill_state_e;

    // Exclusive end of a span starting at base with length len, saturated to
    // limit. Done in 10 bits so base + len can never wrap.
    function automatic logic [9:0] clip_end(input logic [7:0] base,
                                            input logic [8:0] len,
                                            input logic [9:0] limit);
        logic [9:0] sum;
        sum = {2'b00, base} + {1'b0, len};
        return (sum > limit) ? limit : sum;
    endfunction

endpackage

// File: rtl/vmem_fill_ctrl_if.sv
// vmem_fill_ctrl_if
// Bus bundle around the fill controller:
//   cpu_*  : CPU pixel store path (strobe, {y,x} address, colour)
//   cfg_*  : register write strobe/address/data and registered read data
//   vmem_* : arbitrated vmem write port
// The slave modport is the fill controller; the master modport is the side
// that drives CPU/config traffic and consumes the vmem writes.
interface vmem_fill_ctrl_if;

    logic        cpu_we_i;
    logic [15:0] cpu_addr_i;
    logic [2:0]  cpu_wdata_i;

    logic        cfg_we_i;
    logic [3:0]  cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic [31:0] cfg_rdata_o;

    logic        vmem_we_o;
    logic [15:0] vmem_addr_o;
    logic [2:0]  vmem_wdata_o;

    modport slave (
        input  cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  cfg_we_i, cfg_addr_i, cfg_wdata_i,
        output cfg_rdata_o,
        output vmem_we_o, vmem_addr_o, vmem_wdata_o
    );

    modport master (
        output cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output cfg_we_i, cfg_addr_i, cfg_wdata_i,
        input  cfg_rdata_o,
        input  vmem_we_o, vmem_addr_o, vmem_wdata_o
    );

endinterface

// File: rtl/vmem_fill_walker.sv
// vmem_fill_walker
// Raster counter for the fill engine. load_i places the cursor at (x0, y0);
// advance_i steps it one pixel in raster order, wrapping to x0 on the next row
// when the exclusive x_end is reached. last_o flags that the cursor sits on the
// final pixel (x_end-1, y_end-1) of the rectangle.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   load_i, advance_i   : load has priority over advance
//   x0_i, y0_i          : rectangle origin
//   x_end_i, y_end_i    : exclusive, already-clipped end coordinates
//   cx_o, cy_o, last_o  : current cursor and last-pixel flag
module vmem_fill_walker (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       advance_i,
    input  logic [7:0] x0_i,
    input  logic [7:0] y0_i,
    input  logic [8:0] x_end_i,
    input  logic [8:0] y_end_i,
    output logic [7:0] cx_o,
    output logic [7:0] cy_o,
    output logic       last_o
);

    logic [7:0] cx_q, cx_d;
    logic [7:0] cy_q, cy_d;
    logic       row_end;

    // End tests are done one bit wider so cx/cy + 1 cannot wrap to zero.
    assign row_end = (({1'b0, cx_q} + 9'd1) == x_end_i);
    assign last_o  = row_end && (({1'b0, cy_q} + 9'd1) == y_end_i);
    assign cx_o    = cx_q;
    assign cy_o    = cy_q;

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (load_i) begin
            cx_d = x0_i;
            cy_d = y0_i;
        end else if (advance_i) begin
            if (row_end) begin
                cx_d = x0_i;
                cy_d = cy_q + 8'd1;
            end else begin
                cx_d = cx_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

endmodule

// File: rtl/vmem_fill_ctrl.sv
// vmem_fill_ctrl
// Rectangle-fill engine and vmem write-port arbiter. CPU stores always win the
// write port; in RUN, every cycle without a CPU store carries one engine pixel.
// All vmem outputs and the register read data are registered.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : CPU store, register access and vmem write port (slave side)
//   busy_o       : high while the engine is filling (state == RUN)
module vmem_fill_ctrl
    import vmem_fill_ctrl_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    vmem_fill_ctrl_if.slave bus,
    output logic            busy_o
);

    fill_state_e state_q, state_d;

    logic [7:0]  x0_q, x0_d;
    logic [7:0]  y0_q, y0_d;
    logic [8:0]  w_q, w_d;
    logic [8:0]  h_q, h_d;
    logic [2:0]  color_q, color_d;
    logic [8:0]  x_end_q, x_end_d;
    logic [8:0]  y_end_q, y_end_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        vmem_we_q, vmem_we_d;
    logic [15:0] vmem_addr_q, vmem_addr_d;
    logic [2:0]  vmem_wdata_q, vmem_wdata_d;
    logic [31:0] cfg_rdata_q, cfg_rdata_d;

    logic        ctrl_wr, start_req, abort_req;
    logic [9:0]  x_end_clip, y_end_clip;
    logic        origin_off, rect_empty;
    logic        walk_load, walk_advance, walk_last;
    logic [7:0]  cx, cy;
    logic        unused_bits;

    assign busy_o = (state_q == ST_RUN);

    // ABORT wins over START when both bits arrive in one write.
    assign ctrl_wr   = bus.cfg_we_i && (bus.cfg_addr_i[3:2] == REG_CTRL[3:2]);
    assign abort_req = ctrl_wr && bus.cfg_wdata_i[CTRL_ABORT_BIT];
    assign start_req = ctrl_wr && bus.cfg_wdata_i[CTRL_START_BIT] && !abort_req;

    // Clipped rectangle from the stored registers; only consumed at START.
    assign x_end_clip = clip_end(x0_q, w_q, 10'(SCREEN_W));
    assign y_end_clip = clip_end(y0_q, h_q, 10'(SCREEN_H));
    assign origin_off = ({2'b00, x0_q} >= 10'(SCREEN_W)) || ({2'b00, y0_q} >= 10'(SCREEN_H));
    assign rect_empty = (x_end_clip == {2'b00, x0_q}) || (y_end_clip == {2'b00, y0_q});

    assign unused_bits = ^{bus.cfg_wdata_i[31:25], bus.cfg_wdata_i[15:9], bus.cfg_addr_i[1:0]};

    vmem_fill_walker u_walker (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (walk_load),
        .advance_i (walk_advance),
        .x0_i      (x0_q),
        .y0_i      (y0_q),
        .x_end_i   (x_end_q),
        .y_end_i   (y_end_q),
        .cx_o      (cx),
        .cy_o      (cy),
        .last_o    (walk_last)
    );

    // Register file: geometry and colour are frozen while the engine runs, so
    // the walker can use them directly as the values latched at START.
    always_comb begin
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        color_d = color_q;
        if (bus.cfg_we_i && (state_q == ST_IDLE)) begin
            case (bus.cfg_addr_i[3:2])
                REG_ORIGIN[3:2]: begin
                    x0_d = bus.cfg_wdata_i[7:0];
                    y0_d = bus.cfg_wdata_i[23:16];
                end
                REG_SIZE[3:2]: begin
                    w_d = bus.cfg_wdata_i[8:0];
                    h_d = bus.cfg_wdata_i[24:16];
                end
                REG_COLOR[3:2]: color_d = bus.cfg_wdata_i[2:0];
                default: ;
            endcase
        end
    end

    // Registered readback, refreshed every cycle from the current address.
    always_comb begin
        cfg_rdata_d = '0;
        case (bus.cfg_addr_i[3:2])
            REG_CTRL[3:2]: begin
                cfg_rdata_d[STAT_BUSY_BIT] = busy_o;
                cfg_rdata_d[STAT_DONE_BIT] = done_q;
                cfg_rdata_d[STAT_ERR_BIT]  = err_q;
            end
            REG_ORIGIN[3:2]: cfg_rdata_d = {8'h00, y0_q, 8'h00, x0_q};
            REG_SIZE[3:2]:   cfg_rdata_d = {7'h00, h_q, 7'h00, w_q};
            default:         cfg_rdata_d = {29'h0, color_q};
        endcase
    end

    // Next-state logic plus write-port arbitration. A CPU store is forwarded
    // in any state; the engine only takes slots the CPU leaves empty, and
    // issues nothing in the cycle an ABORT is accepted.
    always_comb begin
        state_d      = state_q;
        done_d       = done_q;
        err_d        = err_q;
        x_end_d      = x_end_q;
        y_end_d      = y_end_q;
        walk_load    = 1'b0;
        walk_advance = 1'b0;
        vmem_we_d    = 1'b0;
        vmem_addr_d  = vmem_addr_q;
        vmem_wdata_d = vmem_wdata_q;

        if (bus.cpu_we_i) begin
            vmem_we_d    = 1'b1;
            vmem_addr_d  = bus.cpu_addr_i;
            vmem_wdata_d = bus.cpu_wdata_i;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    if (origin_off) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (rect_empty) begin
                        err_d  = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        err_d     = 1'b0;
                        done_d    = 1'b0;
                        x_end_d   = x_end_clip[8:0];
                        y_end_d   = y_end_clip[8:0];
                        walk_load = 1'b1;
                        state_d   = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort_req) begin
                    state_d = ST_IDLE;
                end else if (!bus.cpu_we_i) begin
                    vmem_we_d    = 1'b1;
                    vmem_addr_d  = {cy, cx};
                    vmem_wdata_d = color_q;
                    walk_advance = 1'b1;
                    if (walk_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All state, including the output registers, clears on reset so a reset
    // mid-fill drops the engine and issues no write in the reset cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            x0_q         <= '0;
            y0_q         <= '0;
            w_q          <= '0;
            h_q          <= '0;
            color_q      <= '0;
            x_end_q      <= '0;
            y_end_q      <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            vmem_we_q    <= 1'b0;
            vmem_addr_q  <= '0;
            vmem_wdata_q <= '0;
            cfg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            w_q          <= w_d;
            h_q          <= h_d;
            color_q      <= color_d;
            x_end_q      <= x_end_d;
            y_end_q      <= y_end_d;
            done_q       <= done_d;
            err_q        <= err_d;
            vmem_we_q    <= vmem_we_d;
            vmem_addr_q  <= vmem_addr_d;
            vmem_wdata_q <= vmem_wdata_d;
            cfg_rdata_q  <= cfg_rdata_d;
        end
    end

    assign bus.vmem_we_o    = vmem_we_q;
    assign bus.vmem_addr_o  = vmem_addr_q;
    assign bus.vmem_wdata_o = vmem_wdata_q;
    assign bus.cfg_rdata_o  = cfg_rdata_q;

endmodule
